// File: rtl/fetch_align_buffer_pkg.sv
// Shared types for the fetch alignment buffer.
//   HW_WIDTH         : width of one buffered halfword
//   instruction_type : raw 32-bit instruction as handed to decode
//   fetch_state_type : fetch request FSM states
//   fetch_out_type   : bundle presented to decode (instr, pc, is_compressed)
package fetch_align_buffer_pkg;

  localparam int HW_WIDTH = 16;

  typedef logic [31:0] instruction_type;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_type;

  typedef struct packed {
    instruction_type instr;
    logic [31:0]     pc;
    logic            is_compressed;
  } fetch_out_type;

  // RVC encodings use every low-bit pattern except 2'b11.
  function automatic logic hw_is_compressed(input logic [HW_WIDTH-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buffer_hw_fifo.sv
// Circular halfword FIFO with multi-entry push/pop.
//   clk, reset_n      : clock, asynchronous active-low reset
//   flush_i           : empty the FIFO; overrides push and pop in the same cycle
//   push_cnt_i        : halfwords to push this cycle (0..2)
//   push_hw0_i/1_i    : first / second halfword to push, in address order
//   pop_cnt_i         : halfwords to pop this cycle (0..2), never above count_o
//   count_o           : halfwords currently stored
//   head0_o/head1_o   : oldest and second-oldest stored halfwords
module fetch_align_buffer_hw_fifo
  import fetch_align_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic [1:0]          push_cnt_i,
  input  logic [HW_WIDTH-1:0] push_hw0_i,
  input  logic [HW_WIDTH-1:0] push_hw1_i,
  input  logic [1:0]          pop_cnt_i,
  output logic [CNT_W-1:0]    count_o,
  output logic [HW_WIDTH-1:0] head0_o,
  output logic [HW_WIDTH-1:0] head1_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [HW_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
    count_d  = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_cnt_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (!flush_i && push_cnt_i != 2'd0) mem_q[wr_ptr_q] <= push_hw0_i;
    if (!flush_i && push_cnt_i == 2'd2) mem_q[wr_ptr_q + PTR_ONE] <= push_hw1_i;
  end

  assign count_o = count_q;
  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + PTR_ONE];

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch alignment buffer between instruction memory and decode.
// Fetches aligned words, buffers halfwords and presents one raw RV32IC
// instruction per cycle (compressed zero-extended, or 32-bit, possibly
// straddling two fetched words), sequencing the PC and handling redirects.
//   clk, reset_n             : clock, asynchronous active-low reset
//   imem_req/imem_addr       : one-cycle word fetch request, word aligned
//   imem_rvalid/imem_rdata   : in-order response, latency >= 1
//   redirect_valid/_pc       : control-flow redirect, highest priority
//   instr_valid/instr_ready  : decode handshake
//   instr/pc_out/is_compressed : instruction presented to decode
// Handshake: an instruction transfers when instr_valid && instr_ready in a
// cycle without redirect_valid; instr/pc_out/is_compressed hold steady while
// instr_valid is high and instr_ready is low.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        is_compressed
);

  localparam int CNT_W = $clog2(BUF_HW + 1);
  // A new request reserves two slots, so it may issue only up to this fill.
  localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(BUF_HW - 2);

  fetch_state_type     state_q;
  logic                drop_q;
  logic                req_en_q;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic                skip_low_q, skip_low_d;

  logic [CNT_W-1:0]    count;
  logic [HW_WIDTH-1:0] head0, head1;
  logic                head_comp, out_valid;
  logic                issue, push_ok, consume;
  logic [1:0]          push_cnt, pop_cnt;
  logic [HW_WIDTH-1:0] push_hw0, push_hw1;
  fetch_out_type       fo;

  fetch_align_buffer_hw_fifo #(.DEPTH(BUF_HW)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (redirect_valid),
    .push_cnt_i (push_cnt),
    .push_hw0_i (push_hw0),
    .push_hw1_i (push_hw1),
    .pop_cnt_i  (pop_cnt),
    .count_o    (count),
    .head0_o    (head0),
    .head1_o    (head1)
  );

  // A 32-bit instruction whose high half is not yet buffered stays invalid.
  assign head_comp = hw_is_compressed(head0);
  assign out_valid = (count != '0 && head_comp) || (count >= CNT_W'(2));

  always_comb begin
    fo    = '0;
    fo.pc = pc_q;
    if (out_valid) begin
      fo.instr         = head_comp ? {16'h0000, head0} : {head1, head0};
      fo.is_compressed = head_comp;
    end
  end

  assign instr_valid   = out_valid;
  assign instr         = fo.instr;
  assign pc_out        = fo.pc;
  assign is_compressed = fo.is_compressed;

  // req_en_q keeps imem_req low while reset is asserted.
  assign issue     = req_en_q && (state_q == F_IDLE) && (count <= ISSUE_MAX) && !redirect_valid;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // A word is kept unless it belongs to a pre-redirect request.
  assign push_ok  = imem_rvalid && (state_q == F_WAIT) && !drop_q && !redirect_valid;
  assign push_cnt = push_ok ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
  assign push_hw0 = skip_low_q ? imem_rdata[31:16] : imem_rdata[15:0];
  assign push_hw1 = imem_rdata[31:16];

  assign consume = out_valid && instr_ready && !redirect_valid;
  assign pop_cnt = consume ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    skip_low_d = skip_low_q;
    if (issue)   fetch_pc_d = fetch_pc_q + 32'd4;
    if (push_ok) skip_low_d = 1'b0;
    if (consume) pc_d = pc_q + (head_comp ? 32'd2 : 32'd4);
    if (redirect_valid) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFE;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      skip_low_d = redirect_pc[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= F_IDLE;
      drop_q     <= 1'b0;
      req_en_q   <= 1'b0;
      pc_q       <= RESET_PC;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      skip_low_q <= RESET_PC[1];
    end else begin
      req_en_q   <= 1'b1;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      skip_low_q <= skip_low_d;
      case (state_q)
        F_IDLE: if (issue) state_q <= F_WAIT;
        F_WAIT: begin
          if (imem_rvalid) begin
            state_q <= F_IDLE;
            drop_q  <= 1'b0;
          end else if (redirect_valid) begin
            // Response still in flight belongs to the old path.
            drop_q  <= 1'b1;
          end
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end

  a_rvalid_only_when_waiting: assert property (
    @(posedge clk) disable iff (!reset_n) imem_rvalid |-> (state_q == F_WAIT)
  );

endmodule

// File: tb/tb_fetch_align_buffer.sv
module tb_fetch_align_buffer;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_rvalid, redirect_valid, instr_valid, instr_ready, is_compressed;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc_out;

  always #5 clk = ~clk;

  fetch_align_buffer #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_out         (pc_out),
    .is_compressed  (is_compressed)
  );

  // ---------------- bench state ----------------
  int tests = 0;
  int fails = 0;
  logic [64:0] exp_q[$];          // {instr, pc, is_compressed}
  logic [31:0] mem_w [0:127];     // 512-byte instruction memory image

  bit          drv_ready, drv_redir_v, redir_on_rv, rand_ready;
  logic [31:0] drv_redir_pc;
  int          lat_min = 1, lat_max = 1;

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] last_req_addr, first_req_addr;
  int          req_count, rv_count;
  bit          last_rv, last_valid;

  typedef struct packed {
    logic [31:0]       w0;
    logic [31:0]       w1;
    logic [1:0]        n;
    logic [2:0][31:0]  ei;
    logic [2:0][31:0]  ep;
    logic [2:0]        ec;
  } vec_t;
  vec_t vecs [4];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_hw(input logic [31:0] a, input logic [15:0] hw);
    if (a[1]) mem_w[a[8:2]][31:16] = hw;
    else      mem_w[a[8:2]][15:0]  = hw;
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_q.push_back({i, p, c});
  endtask

  // One cycle: drive inputs at negedge, sample outputs 1 time unit later.
  task automatic step();
    bit rv;
    logic [64:0] e;
    @(negedge clk);
    rv = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        rv   = 1'b1;
        pend = 1'b0;
      end
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_w[pend_addr[8:2]] : $urandom();
    if (rand_ready) drv_ready = ($urandom_range(0, 9) < 7);
    instr_ready    = drv_ready || (redir_on_rv && rv);
    redirect_valid = drv_redir_v || (redir_on_rv && rv);
    redirect_pc    = drv_redir_pc;
    last_rv = rv;
    if (rv) rv_count++;
    #1;
    last_valid = instr_valid;
    if (imem_req) begin
      check("req_while_outstanding", {64'd0, pend}, 65'd0);
      check("req_addr_aligned", {63'd0, imem_addr[1:0]}, 65'd0);
      if (req_count == 0) first_req_addr = imem_addr;
      pend          = 1'b1;
      pend_addr     = imem_addr;
      pend_cnt      = $urandom_range(lat_min, lat_max);
      last_req_addr = imem_addr;
      req_count++;
    end
    if (instr_valid && instr_ready && !redirect_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instr_out", {instr, pc_out, is_compressed}, e);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n        = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    drv_ready      = 1'b0;
    drv_redir_v    = 1'b0;
    redir_on_rv    = 1'b0;
    rand_ready     = 1'b0;
    pend           = 1'b0;
    req_count      = 0;
    rv_count       = 0;
    exp_q.delete();
    #1;
    check("rst_instr_valid", {64'd0, instr_valid}, 65'd0);
    check("rst_imem_req", {64'd0, imem_req}, 65'd0);
    check("rst_instr", {33'd0, instr}, 65'd0);
    check("rst_is_compressed", {64'd0, is_compressed}, 65'd0);
    check("rst_pc_out", {33'd0, pc_out}, 65'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check(name, 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0; drv_redir_pc = '0;
    for (int i = 0; i < 128; i++) mem_w[i] = 32'h0001_0001;

    // Vector table: two memory words at address 0, expected first outputs.
    vecs[0] = '0; vecs[0].w0 = 32'h0000_0013; vecs[0].w1 = 32'h0010_0093; vecs[0].n = 2;
    vecs[0].ei[0] = 32'h0000_0013; vecs[0].ep[0] = 32'h0; vecs[0].ec[0] = 1'b0;
    vecs[0].ei[1] = 32'h0010_0093; vecs[0].ep[1] = 32'h4; vecs[0].ec[1] = 1'b0;
    vecs[1] = '0; vecs[1].w0 = 32'h4505_0001; vecs[1].w1 = 32'h0000_0013; vecs[1].n = 2;
    vecs[1].ei[0] = 32'h0000_0001; vecs[1].ep[0] = 32'h0; vecs[1].ec[0] = 1'b1;
    vecs[1].ei[1] = 32'h0000_4505; vecs[1].ep[1] = 32'h2; vecs[1].ec[1] = 1'b1;
    // c.nop, then addi a0,x0,10 (0x00A00513) straddling into word 1, then c.nop
    vecs[2] = '0; vecs[2].w0 = 32'h0513_0001; vecs[2].w1 = 32'h0001_00A0; vecs[2].n = 3;
    vecs[2].ei[0] = 32'h0000_0001; vecs[2].ep[0] = 32'h0; vecs[2].ec[0] = 1'b1;
    vecs[2].ei[1] = 32'h00A0_0513; vecs[2].ep[1] = 32'h2; vecs[2].ec[1] = 1'b0;
    vecs[2].ei[2] = 32'h0000_0001; vecs[2].ep[2] = 32'h6; vecs[2].ec[2] = 1'b1;
    vecs[3] = '0; vecs[3].w0 = 32'h0010_0093; vecs[3].w1 = 32'h0001_0001; vecs[3].n = 3;
    vecs[3].ei[0] = 32'h0010_0093; vecs[3].ep[0] = 32'h0; vecs[3].ec[0] = 1'b0;
    vecs[3].ei[1] = 32'h0000_0001; vecs[3].ep[1] = 32'h4; vecs[3].ec[1] = 1'b1;
    vecs[3].ei[2] = 32'h0000_0001; vecs[3].ep[2] = 32'h6; vecs[3].ec[2] = 1'b1;

    for (int v = 0; v < 4; v++) begin
      reset_dut();
      lat_min = 1; lat_max = 2;
      mem_w[0] = vecs[v].w0;
      mem_w[1] = vecs[v].w1;
      mem_w[2] = 32'h0001_0001;
      mem_w[3] = 32'h0001_0001;
      for (int k = 0; k < 3; k++)
        if (k < int'(vecs[v].n)) push_exp(vecs[v].ei[k], vecs[v].ep[k], vecs[v].ec[k]);
      drv_ready = 1'b1;
      drain($sformatf("vec%0d_drain", v), 60);
      if (v == 0) check("first_req_addr", {33'd0, first_req_addr}, 65'd0);
    end

    // Stall with a full buffer: outputs stable, no fetch, nothing lost afterwards.
    reset_dut();
    lat_min = 1; lat_max = 1;
    mem_w[0] = 32'h0000_0013; mem_w[1] = 32'h0010_0093; mem_w[2] = 32'h0001_0001;
    push_exp(32'h0000_0013, 32'h0, 1'b0);
    push_exp(32'h0010_0093, 32'h4, 1'b0);
    push_exp(32'h0000_0001, 32'h8, 1'b1);
    push_exp(32'h0000_0001, 32'hA, 1'b1);
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {64'd0, instr_valid}, 65'd1);
      check("hold_instr", {33'd0, instr}, 65'h13);
      check("hold_pc", {33'd0, pc_out}, 65'd0);
      check("hold_no_req", {64'd0, imem_req}, 65'd0);
    end
    drv_ready = 1'b1;
    drain("hold_drain", 60);

    // Redirect to 0x102 while a request is in flight.
    reset_dut();
    lat_min = 3; lat_max = 3;
    mem_w[0] = 32'h0001_0001;
    mem_w[7'h40] = 32'h4505_FFFF;
    mem_w[7'h41] = 32'h0000_0013;
    for (int i = 0; i < 10 && req_count == 0; i++) step();
    check("redir_first_req_seen", 65'(req_count), 65'd1);
    drv_redir_v = 1'b1; drv_redir_pc = 32'h0000_0102;
    step();
    drv_redir_v = 1'b0;
    push_exp(32'h0000_4505, 32'h102, 1'b1);
    push_exp(32'h0000_0013, 32'h104, 1'b0);
    drv_ready = 1'b1;
    for (int i = 0; i < 12 && req_count < 2; i++) step();
    check("redir_fetch_addr", {33'd0, last_req_addr}, 65'h100);
    drain("redir_drain", 60);

    // Redirect coinciding with a response and a ready decode.
    reset_dut();
    lat_min = 2; lat_max = 2;
    mem_w[0] = 32'h0001_0001; mem_w[1] = 32'h0001_0001;
    mem_w[7'h10] = 32'h0000_0013; mem_w[7'h11] = 32'h0000_0013;
    for (int i = 0; i < 12 && rv_count < 1; i++) step();
    redir_on_rv = 1'b1; drv_redir_pc = 32'h0000_0040;
    last_rv = 1'b0;
    for (int i = 0; i < 12 && !last_rv; i++) step();
    check("same_valid_before", {64'd0, last_valid}, 65'd1);
    redir_on_rv = 1'b0;
    step();
    check("same_valid_after", {64'd0, instr_valid}, 65'd0);
    check("same_pc_after", {33'd0, pc_out}, 65'h40);
    push_exp(32'h0000_0013, 32'h40, 1'b0);
    push_exp(32'h0000_0013, 32'h44, 1'b0);
    drv_ready = 1'b1;
    drain("same_drain", 60);

    // Random instruction streams, random latency and decode stalls.
    for (int r = 0; r < 3; r++) begin
      logic [31:0] pc, w;
      logic [15:0] hw;
      reset_dut();
      lat_min = 1; lat_max = 3;
      pc = 32'h0;
      while (pc < 32'h1F0) begin
        if ($urandom_range(0, 1) == 1) begin
          hw = 16'($urandom());
          if (hw[1:0] == 2'b11) hw[0] = 1'b0;
          set_hw(pc, hw);
          push_exp({16'h0, hw}, pc, 1'b1);
          pc = pc + 32'd2;
        end else begin
          w = $urandom() | 32'h3;
          set_hw(pc, w[15:0]);
          set_hw(pc + 32'd2, w[31:16]);
          push_exp(w, pc, 1'b0);
          pc = pc + 32'd4;
        end
      end
      rand_ready = 1'b1;
      drain($sformatf("rand%0d_drain", r), 3000);
      rand_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
